// File: rtl/bananachine_pkg.sv
// rtl/bananachine_pkg.sv - shared sprite address map, raster size and fetcher state encoding
package bananachine_pkg;

    localparam int unsigned MXP  = 6000;
    localparam int unsigned MYP  = 6004;
    localparam int unsigned P1XP = 6008;
    localparam int unsigned P1YP = 6012;
    localparam int unsigned P2XP = 6016;
    localparam int unsigned P2YP = 6020;

    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 480;

    localparam int unsigned NUM_COORDS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/sprite_position_fetcher_clamp.sv
// rtl/sprite_position_fetcher_clamp.sv - unsigned min(value, limit) on the capture path
module coord_clamp #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] clamped_o
);

    assign clamped_o = (value_i > limit_i) ? limit_i : value_i;

endmodule

// File: rtl/sprite_position_fetcher.sv
// rtl/sprite_position_fetcher.sv - per-frame fetch of six sprite coordinates with clamp and atomic commit
module sprite_position_fetcher
    import bananachine_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int H_RES = bananachine_pkg::H_RES,
    parameter int V_RES = bananachine_pkg::V_RES,
    parameter int MXP   = bananachine_pkg::MXP,
    parameter int MYP   = bananachine_pkg::MYP,
    parameter int P1XP  = bananachine_pkg::P1XP,
    parameter int P1YP  = bananachine_pkg::P1YP,
    parameter int P2XP  = bananachine_pkg::P2XP,
    parameter int P2YP  = bananachine_pkg::P2YP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [WIDTH-1:0] data_from_mem_vga,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mx,
    output logic [WIDTH-1:0] my,
    output logic [WIDTH-1:0] p1x,
    output logic [WIDTH-1:0] p1y,
    output logic [WIDTH-1:0] p2x,
    output logic [WIDTH-1:0] p2y,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam logic [2:0]       LAST_IDX = 3'(NUM_COORDS - 1);
    localparam logic [WIDTH-1:0] X_LIMIT  = WIDTH'(H_RES - 1);
    localparam logic [WIDTH-1:0] Y_LIMIT  = WIDTH'(V_RES - 1);

    fetch_state_e     state_q, state_d;
    logic [2:0]       index_q, index_d;
    logic [2:0]       cap_idx_q;
    logic             cap_en_q;
    logic             overrun_q;
    logic [WIDTH-1:0] shadow_q [0:NUM_COORDS-2];
    logic [WIDTH-1:0] coord_q  [0:NUM_COORDS-1];
    logic [WIDTH-1:0] clamp_limit;
    logic [WIDTH-1:0] clamped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = '0;
        case (state_q)
            ST_IDLE:  if (frame_start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (index_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    index_d = index_q + 3'd1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        frame_done = (state_q == ST_DONE);
    end

    always_comb begin
        case (index_q)
            3'd0:    mem_address = WIDTH'(MXP);
            3'd1:    mem_address = WIDTH'(MYP);
            3'd2:    mem_address = WIDTH'(P1XP);
            3'd3:    mem_address = WIDTH'(P1YP);
            3'd4:    mem_address = WIDTH'(P2XP);
            3'd5:    mem_address = WIDTH'(P2YP);
            default: mem_address = WIDTH'(MXP);
        endcase
    end

    // Odd capture indices are Y words.
    assign clamp_limit = cap_idx_q[0] ? Y_LIMIT : X_LIMIT;

    coord_clamp #(.WIDTH(WIDTH)) u_clamp (
        .value_i   (data_from_mem_vga),
        .limit_i   (clamp_limit),
        .clamped_o (clamped)
    );

    // RAM read data lags its address by one cycle, so capture tracks the previous index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_q   <= '0;
            cap_idx_q <= '0;
            cap_en_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            index_q   <= index_d;
            cap_idx_q <= index_q;
            cap_en_q  <= (state_q == ST_FETCH);
            overrun_q <= frame_start && (state_q != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_COORDS - 1; k++) shadow_q[k] <= '0;
            for (int k = 0; k < NUM_COORDS; k++)     coord_q[k]  <= '0;
        end else begin
            for (int k = 0; k < NUM_COORDS - 1; k++) begin
                if (cap_en_q && cap_idx_q == 3'(k)) shadow_q[k] <= clamped;
            end
            // Last word bypasses the shadow so all six commit on the same edge.
            if (state_q == ST_DRAIN) begin
                for (int k = 0; k < NUM_COORDS - 1; k++) coord_q[k] <= shadow_q[k];
                coord_q[NUM_COORDS-1] <= clamped;
            end
        end
    end

    assign mx      = coord_q[0];
    assign my      = coord_q[1];
    assign p1x     = coord_q[2];
    assign p1y     = coord_q[3];
    assign p2x     = coord_q[4];
    assign p2y     = coord_q[5];
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_position_fetcher.sv
// tb/tb_sprite_position_fetcher.sv - directed vector bench for sprite_position_fetcher
module tb_sprite_position_fetcher;

    typedef logic [5:0][15:0] coords_t;

    typedef struct {
        coords_t ram_vals;
        coords_t expected;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [15:0] data_from_mem_vga;
    logic [15:0] mem_address;
    logic [15:0] mx, my, p1x, p1y, p2x, p2y;
    logic        busy, frame_done, overrun;

    logic [15:0] ram [0:8191];

    int n_checks;
    int n_fail;

    sprite_position_fetcher dut (
        .clk               (clk),
        .reset             (reset),
        .frame_start       (frame_start),
        .data_from_mem_vga (data_from_mem_vga),
        .mem_address       (mem_address),
        .mx                (mx),
        .my                (my),
        .p1x               (p1x),
        .p1y               (p1y),
        .p2x               (p2x),
        .p2y               (p2y),
        .busy              (busy),
        .frame_done        (frame_done),
        .overrun           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) data_from_mem_vga <= ram[mem_address[12:0]];

    function automatic coords_t mk(input int a0, a1, a2, a3, a4, a5);
        coords_t c;
        c[0] = 16'(a0); c[1] = 16'(a1); c[2] = 16'(a2);
        c[3] = 16'(a3); c[4] = 16'(a4); c[5] = 16'(a5);
        return c;
    endfunction

    function automatic coords_t got();
        coords_t c;
        c[0] = mx; c[1] = my; c[2] = p1x; c[3] = p1y; c[4] = p2x; c[5] = p2y;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_coords(input string name, input coords_t exp);
        coords_t g;
        g = got();
        for (int k = 0; k < 6; k++) check($sformatf("%s coord%0d", name, k), 32'(g[k]), 32'(exp[k]));
    endtask

    task automatic load_ram(input coords_t v);
        for (int k = 0; k < 6; k++) ram[13'(6000 + 4 * k)] = v[k];
    endtask

    // Starts in cycle N (IDLE), returns in cycle N+10.
    task automatic run_frame(input string tag, input coords_t exp, input coords_t old);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 6) check($sformatf("%s addr N+%0d", tag, c), 32'(mem_address), 32'(6000 + 4 * (c - 1)));
            if (c <= 7) begin
                check($sformatf("%s busy N+%0d", tag, c), 32'(busy), 32'd1);
                check($sformatf("%s done N+%0d", tag, c), 32'(frame_done), 32'd0);
                check_coords($sformatf("%s hold N+%0d", tag, c), old);
            end else if (c == 8) begin
                check($sformatf("%s busy N+8", tag), 32'(busy), 32'd0);
                check($sformatf("%s done N+8", tag), 32'(frame_done), 32'd1);
                check_coords($sformatf("%s commit", tag), exp);
            end else begin
                check($sformatf("%s busy N+9", tag), 32'(busy), 32'd0);
                check($sformatf("%s done N+9", tag), 32'(frame_done), 32'd0);
                check($sformatf("%s addr N+9", tag), 32'(mem_address), 32'd6000);
            end
            check($sformatf("%s overrun N+%0d", tag, c), 32'(overrun), 32'd0);
            tick();
        end
    endtask

    vec_t    vecs [5];
    coords_t prev;
    coords_t zero;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        zero     = '0;
        for (int a = 0; a < 8192; a++) ram[a] = 16'd0;

        vecs[0] = '{ram_vals: mk(100, 200, 300, 50, 5, 479),        expected: mk(100, 200, 300, 50, 5, 479)};
        vecs[1] = '{ram_vals: mk(700, 480, 300, 50, 65535, 479),    expected: mk(639, 479, 300, 50, 639, 479)};
        vecs[2] = '{ram_vals: mk(639, 479, 640, 480, 638, 478),     expected: mk(639, 479, 639, 479, 638, 478)};
        vecs[3] = '{ram_vals: mk(0, 1000, 1, 65535, 479, 481),      expected: mk(0, 479, 1, 479, 479, 479)};
        vecs[4] = '{ram_vals: mk(0, 0, 0, 0, 0, 0),                 expected: mk(0, 0, 0, 0, 0, 0)};

        reset       = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        load_ram(vecs[0].ram_vals);
        for (int c = 0; c < 5; c++) tick();
        check_coords("reset", zero);
        check("reset addr", 32'(mem_address), 32'd6000);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(frame_done), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);

        prev = zero;
        for (int v = 0; v < 5; v++) begin
            load_ram(vecs[v].ram_vals);
            run_frame($sformatf("vec%0d", v), vecs[v].expected, prev);
            prev = vecs[v].expected;
        end

        // Overrun: second frame_start at N+3 is dropped.
        load_ram(vecs[0].ram_vals);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        frame_start = 1'b1;
        check("ovr overrun N+3", 32'(overrun), 32'd0);
        tick();
        frame_start = 1'b0;
        check("ovr overrun N+4", 32'(overrun), 32'd1);
        check("ovr busy N+4", 32'(busy), 32'd1);
        check("ovr addr N+4", 32'(mem_address), 32'd6012);
        tick();
        check("ovr overrun N+5", 32'(overrun), 32'd0);
        tick();
        tick();
        check_coords("ovr hold N+7", prev);
        tick();
        check_coords("ovr commit", vecs[0].expected);
        check("ovr done N+8", 32'(frame_done), 32'd1);
        tick();
        check("ovr busy N+9", 32'(busy), 32'd0);
        tick();
        check("ovr busy N+10", 32'(busy), 32'd0);
        check("ovr addr N+10", 32'(mem_address), 32'd6000);
        check("ovr done N+10", 32'(frame_done), 32'd0);
        tick();

        // Reset asserted mid-fetch at N+4.
        load_ram(vecs[1].ram_vals);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_coords("rst async", zero);
        check("rst busy", 32'(busy), 32'd0);
        check("rst addr", 32'(mem_address), 32'd6000);
        check("rst done", 32'(frame_done), 32'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("rst idle busy", 32'(busy), 32'd0);
        check("rst idle done", 32'(frame_done), 32'd0);
        check_coords("rst no commit", zero);
        run_frame("postrst", vecs[1].expected, zero);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
